mdio_slave: RTL and testbench
=============================

// Module: mdio_slave
// PURPOSE
//  Clause-22 MDIO responder (PHY side) for the management bus driven by our MDIO master.
//  Oversamples MDC/MDIO on the system clock and decodes read/write frames addressed to phy_addr.
//  Issues single-cycle accesses to a local 32x16 register bank; drives read data back on MDIO.
//  Sits in PHY-emulation and loopback test fabrics opposite the master controller.
// PARAMETERS
//  SYNC_STAGES  2   synchronizer flops on mdc and mdio_i (>=2)
//  PRE_MIN      32  consecutive sampled 1s required before a start-of-frame is accepted
// PORTS
//  clk        in   1   system clock
//  rst        in   1   synchronous active-high reset
//  mdc        in   1   management clock from station (async to clk)
//  mdio_i     in   1   MDIO pad input
//  mdio_o     out  1   MDIO pad output value
//  mdio_oe    out  1   MDIO pad output enable (1 = drive)
//  phy_addr   in   5   address this responder answers to (static)
//  reg_addr   out  5   register address of current access, held after capture
//  reg_wdata  out  16  write data, valid with reg_wr
//  reg_wr     out  1   one-cycle write strobe
//  reg_rd     out  1   one-cycle read strobe
//  reg_rdata  in   16  read data, sampled exactly 1 clk after reg_rd
//  frame_err  out  1   one-cycle pulse on aborted frame (bad SOF or invalid OP)
// BEHAVIOUR
//  Reset: mdio_oe=0, mdio_o=1, reg_wr=0, reg_rd=0, frame_err=0, reg_addr=0, reg_wdata=0,
//   state=IDLE, preamble count=0. Reset mid-frame releases MDIO in the same cycle it applies.
//  Edge detect: rise = sync_mdc & !sync_mdc_d. All frame logic advances only on rise cycles,
//   sampling synchronized mdio_i. MDC high and low each >= SYNC_STAGES+3 clk required.
//  Output timing: mdio_o/mdio_oe change on the clk after a rise cycle (station samples on MDC fall).
//  Frame after preamble: SOF(01) OP(2) PADR(5) RADR(5) TA(2) DATA(16), MSB first.
//  States/transitions (per rise):
//   IDLE: bit=1 -> pre_cnt++ (saturate at PRE_MIN); bit=0 -> SOF if pre_cnt>=PRE_MIN else pre_cnt=0.
//   SOF : bit=1 -> OP; bit=0 -> IDLE, frame_err pulse.
//   OP  : 2 bits; 10=read, 01=write; 00/11 -> IDLE, frame_err pulse.
//   PADR: 5 bits; mismatch with phy_addr -> IDLE silently after 5th bit, never drives.
//   RADR: 5 bits; on 5th bit reg_addr loaded; if read, reg_rd pulses same cycle.
//   TA  : read: bit1 hi-Z; after bit1 rise drive oe=1, o=0; after bit2 rise o=rdata[15].
//         write: 2 bits counted, values ignored.
//   DATA: read: after each rise shift next bit out; after 16th rise oe=0 (o=1), -> IDLE.
//         write: shift in 16 bits; on 16th rise reg_wdata loaded, reg_wr pulses next clk, -> IDLE.
//  Every exit to IDLE clears pre_cnt; a new frame always needs PRE_MIN fresh 1s.
//  reg_rd and reg_wr never both asserted; at most one strobe per frame.
//  Read data latched into a 16-bit shift register 1 clk after reg_rd; later reg_rdata changes ignored.
// TESTING
//  Reset, phy_addr=1, idle MDC/MDIO high -> oe=0, no strobes, frame_err=0.
//  32x1, write PHY1 REG5 0xA5C3 -> single reg_wr with reg_addr=5, reg_wdata=0xA5C3; oe stays 0.
//  32x1, read PHY1 REG2, bank returns 0x1234 -> reg_rd once; MDIO: Z,0,then 0x1234 MSB-first; oe=0 after.
//  Read to PHY 3 with phy_addr=1 -> no reg_rd, oe never asserted, next valid frame decoded normally.
//  Only 31 preamble 1s then write frame -> no reg_wr; SOF 00 after 32x1 -> frame_err pulse, no strobe.
//  rst asserted during read DATA bit 7 -> oe=0 next clk; following full write frame decodes correctly.

Source files
------------

// File: rtl/mdio_slave_if.sv
// MDIO pad pins and local register-bank port of the Clause-22 responder.
// The slave modport is the PHY side; master is the station/bank environment.
interface mdio_slave_if;
  logic        mdc;
  logic        mdio_i;
  logic        mdio_o;
  logic        mdio_oe;
  logic [4:0]  reg_addr;
  logic [15:0] reg_wdata;
  logic        reg_wr;
  logic        reg_rd;
  logic [15:0] reg_rdata;

  modport slave (
    input  mdc, mdio_i, reg_rdata,
    output mdio_o, mdio_oe, reg_addr, reg_wdata, reg_wr, reg_rd
  );

  modport master (
    output mdc, mdio_i, reg_rdata,
    input  mdio_o, mdio_oe, reg_addr, reg_wdata, reg_wr, reg_rd
  );
endinterface

// File: rtl/mdio_slave.sv
// Clause-22 MDIO responder: oversamples MDC/MDIO on clk, decodes frames for phy_addr
// and issues single-cycle accesses to an external 32x16 register bank.
module mdio_slave #(
  parameter int SYNC_STAGES = 2,
  parameter int PRE_MIN     = 32
) (
  input  logic         clk,
  input  logic         rst,
  mdio_slave_if.slave  bus,
  input  logic [4:0]   phy_addr,
  output logic         frame_err
);

  typedef enum logic [2:0] {S_IDLE, S_SOF, S_OP, S_PADR, S_RADR, S_TA, S_DATA} state_t;

  localparam int PW = $clog2(PRE_MIN + 1);
  localparam logic [PW-1:0] PRE_FULL = PW'(PRE_MIN);

  logic [SYNC_STAGES-1:0] mdc_sync, mdio_sync;
  logic                   mdc_d;
  logic                   rise, bit_in;

  state_t        state_q, state_n;
  logic [PW-1:0] pre_q, pre_n;
  logic [3:0]    cnt_q, cnt_n;
  logic          rd_q, rd_n;
  logic [15:0]   sh_q, sh_n;
  logic          oe_q, oe_n, o_q, o_n;
  logic [4:0]    addr_q, addr_n;
  logic [15:0]   wdata_q, wdata_n;
  logic          wr_q, wr_n, rdstb_q, rdstb_n, err_q, err_n;
  logic          rd_pend_q;

  // Idle bus level is high, so the chains reset to 1 to avoid a false rise after reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      mdc_sync  <= '1;
      mdio_sync <= '1;
      mdc_d     <= 1'b1;
    end else begin
      mdc_sync  <= {mdc_sync[SYNC_STAGES-2:0], bus.mdc};
      mdio_sync <= {mdio_sync[SYNC_STAGES-2:0], bus.mdio_i};
      mdc_d     <= mdc_sync[SYNC_STAGES-1];
    end
  end

  assign rise   = mdc_sync[SYNC_STAGES-1] & ~mdc_d;
  assign bit_in = mdio_sync[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      pre_q     <= '0;
      cnt_q     <= '0;
      rd_q      <= 1'b0;
      sh_q      <= '0;
      oe_q      <= 1'b0;
      o_q       <= 1'b1;
      addr_q    <= '0;
      wdata_q   <= '0;
      wr_q      <= 1'b0;
      rdstb_q   <= 1'b0;
      err_q     <= 1'b0;
      rd_pend_q <= 1'b0;
    end else begin
      state_q   <= state_n;
      pre_q     <= pre_n;
      cnt_q     <= cnt_n;
      rd_q      <= rd_n;
      sh_q      <= sh_n;
      oe_q      <= oe_n;
      o_q       <= o_n;
      addr_q    <= addr_n;
      wdata_q   <= wdata_n;
      wr_q      <= wr_n;
      rdstb_q   <= rdstb_n;
      err_q     <= err_n;
      rd_pend_q <= rdstb_q;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_n = state_q;
    pre_n   = pre_q;
    cnt_n   = cnt_q;
    rd_n    = rd_q;
    sh_n    = sh_q;
    oe_n    = oe_q;
    o_n     = o_q;
    addr_n  = addr_q;
    wdata_n = wdata_q;
    wr_n    = 1'b0;
    rdstb_n = 1'b0;
    err_n   = 1'b0;

    // The bank answers one clk after reg_rd; capture once, ignore later changes.
    if (rd_pend_q) sh_n = bus.reg_rdata;

    if (rise) begin
      cnt_n = cnt_q + 4'd1;
      unique case (state_q)
        S_IDLE: begin
          cnt_n = '0;
          if (bit_in) begin
            if (pre_q < PRE_FULL) pre_n = pre_q + PW'(1);
          end else if (pre_q >= PRE_FULL) begin
            state_n = S_SOF;
          end else begin
            pre_n = '0;
          end
        end
        S_SOF: begin
          cnt_n = '0;
          if (bit_in) state_n = S_OP;
          else begin
            state_n = S_IDLE;
            err_n   = 1'b1;
          end
        end
        S_OP: begin
          if (cnt_q == 4'd0) rd_n = bit_in;
          else if (rd_q != bit_in) begin
            state_n = S_PADR;
            cnt_n   = '0;
          end else begin
            state_n = S_IDLE;
            err_n   = 1'b1;
          end
        end
        S_PADR: begin
          sh_n = {sh_q[14:0], bit_in};
          if (cnt_q == 4'd4) begin
            cnt_n   = '0;
            state_n = ({sh_q[3:0], bit_in} == phy_addr) ? S_RADR : S_IDLE;
          end
        end
        S_RADR: begin
          sh_n = {sh_q[14:0], bit_in};
          if (cnt_q == 4'd4) begin
            cnt_n   = '0;
            addr_n  = {sh_q[3:0], bit_in};
            rdstb_n = rd_q;
            state_n = S_TA;
          end
        end
        S_TA: begin
          if (cnt_q == 4'd0) begin
            if (rd_q) begin
              oe_n = 1'b1;
              o_n  = 1'b0;
            end
          end else begin
            cnt_n   = '0;
            state_n = S_DATA;
            if (rd_q) begin
              o_n  = sh_q[15];
              sh_n = {sh_q[14:0], 1'b0};
            end
          end
        end
        S_DATA: begin
          if (rd_q) begin
            if (cnt_q == 4'd15) begin
              oe_n    = 1'b0;
              o_n     = 1'b1;
              state_n = S_IDLE;
            end else begin
              o_n  = sh_q[15];
              sh_n = {sh_q[14:0], 1'b0};
            end
          end else begin
            sh_n = {sh_q[14:0], bit_in};
            if (cnt_q == 4'd15) begin
              wdata_n = {sh_q[14:0], bit_in};
              wr_n    = 1'b1;
              state_n = S_IDLE;
            end
          end
        end
        default: state_n = S_IDLE;
      endcase
    end

    // A new frame always needs a fresh preamble.
    if (state_q != S_IDLE || state_n != S_IDLE) pre_n = '0;
  end

  // Gating with rst releases the pad in the very cycle reset is applied.
  assign bus.mdio_oe   = oe_q & ~rst;
  assign bus.mdio_o    = o_q | rst;
  assign bus.reg_addr  = addr_q;
  assign bus.reg_wdata = wdata_q;
  assign bus.reg_wr    = wr_q;
  assign bus.reg_rd    = rdstb_q;
  assign frame_err     = err_q;

endmodule

// File: tb/tb_mdio_slave.sv
// Self-checking bench for mdio_slave: station model drives frames, a frame-level model
// predicts pad values at each MDC fall plus strobe counts, addresses and data.
module tb_mdio_slave;

  localparam int HALF = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  phy_addr;
  logic        frame_err;
  logic        st_drv;
  logic        load_bank;

  mdio_slave_if bus();

  mdio_slave #(.SYNC_STAGES(2), .PRE_MIN(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .phy_addr  (phy_addr),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  // Open-drain style bus: the responder wins when it drives, else the station value.
  assign bus.mdio_i = bus.mdio_oe ? bus.mdio_o : st_drv;

  int          n_vec = 0;
  int          n_fail = 0;
  int          n_wr = 0, n_rd = 0, n_err = 0;
  logic [4:0]  wr_addr, rd_addr;
  logic [15:0] wr_data;
  logic [15:0] seed    [32];
  logic [15:0] bank    [32];
  logic [15:0] mdl_mem [32];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  // Register bank with one-cycle read latency; junk on the data bus otherwise.
  always @(posedge clk) begin
    if (load_bank) begin
      for (int i = 0; i < 32; i++) bank[i] <= seed[i];
    end else if (bus.reg_wr) begin
      bank[bus.reg_addr] <= bus.reg_wdata;
    end
    if (bus.reg_rd) bus.reg_rdata <= bank[bus.reg_addr];
    else            bus.reg_rdata <= 16'($urandom);
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.reg_wr || bus.reg_rd)
        check("one_strobe", {31'd0, bus.reg_wr & bus.reg_rd}, 32'd0);
      if (bus.reg_wr) begin
        n_wr++;
        wr_addr = bus.reg_addr;
        wr_data = bus.reg_wdata;
      end
      if (bus.reg_rd) begin
        n_rd++;
        rd_addr = bus.reg_addr;
      end
      if (frame_err) n_err++;
    end
  end

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One MDC period: data set up in the low phase, sampled just before the next fall.
  task automatic mdc_cycle(input logic b, input logic do_rst, output logic s_oe, output logic s_o);
    st_drv  = b;
    bus.mdc = 1'b0;
    wait_clks(HALF);
    bus.mdc = 1'b1;
    wait_clks(HALF);
    s_oe = bus.mdio_oe;
    s_o  = bus.mdio_o;
    if (do_rst) begin
      rst = 1'b1;
      wait_clks(1);
      check("rst_oe", {31'd0, bus.mdio_oe}, 32'd0);
      check("rst_o", {31'd0, bus.mdio_o}, 32'd1);
      check("rst_addr", {27'd0, bus.reg_addr}, 32'd0);
      rst = 1'b0;
      wait_clks(2);
    end
  endtask

  task automatic send_frame(input int npre, input logic [1:0] sof, input logic [1:0] op,
                            input logic [4:0] pa, input logic [4:0] ra, input logic [15:0] wd,
                            input int nbits, input int rst_slot, output logic [15:0] got);
    logic [31:0] fr;
    logic        valid, is_rd, addressed, s_oe, s_o;
    logic [1:0]  exp_pin;
    logic [15:0] rd_word;
    int          wr0, rd0, err0, sent;
    bit          exp_wr, exp_rs, exp_err;
    wr0  = n_wr;
    rd0  = n_rd;
    err0 = n_err;
    is_rd     = (op == 2'b10);
    valid     = (npre >= 32) && (sof == 2'b01) && (op == 2'b10 || op == 2'b01);
    addressed = valid && (pa == phy_addr);
    rd_word   = mdl_mem[ra];
    fr  = {sof, op, pa, ra, (is_rd ? 18'h3FFFF : {2'b10, wd})};
    got = '0;
    for (int i = 0; i < npre; i++) begin
      mdc_cycle(1'b1, 1'b0, s_oe, s_o);
      check("pre_pin", {30'd0, s_oe, s_o}, 32'd1);
    end
    sent = 0;
    for (int i = 0; i < nbits; i++) begin
      mdc_cycle(fr[31-i], i == rst_slot, s_oe, s_o);
      exp_pin = 2'b01;
      if (addressed && is_rd && i == 14) exp_pin = 2'b10;
      else if (addressed && is_rd && i >= 15 && i <= 30) exp_pin = {1'b1, rd_word[30-i]};
      check("mdio_pin", {30'd0, s_oe, s_o}, {30'd0, exp_pin});
      if (i >= 15 && i <= 30) got[30-i] = s_o;
      sent = i + 1;
      if (i == rst_slot) break;
    end
    wait_clks(4);
    exp_wr  = addressed && !is_rd && sent == 32;
    exp_rs  = addressed && is_rd && sent >= 14;
    exp_err = (npre >= 32) && ((sof == 2'b00 && sent >= 2) ||
              (sof == 2'b01 && sent >= 4 && (op == 2'b00 || op == 2'b11)));
    check("wr_count", n_wr - wr0, {31'd0, exp_wr});
    check("rd_count", n_rd - rd0, {31'd0, exp_rs});
    check("err_count", n_err - err0, {31'd0, exp_err});
    if (exp_wr) begin
      check("wr_addr", {27'd0, wr_addr}, {27'd0, ra});
      check("wr_data", {16'd0, wr_data}, {16'd0, wd});
      mdl_mem[ra] = wd;
    end
    if (exp_rs) check("rd_addr", {27'd0, rd_addr}, {27'd0, ra});
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time budget exceeded");
    $fatal(1);
  end

  initial begin
    logic [15:0] got;
    logic [1:0]  op;
    logic [4:0]  pa;
    int          kind;
    rst       = 1'b1;
    phy_addr  = 5'd1;
    bus.mdc   = 1'b1;
    st_drv    = 1'b1;
    load_bank = 1'b1;
    for (int i = 0; i < 32; i++) begin
      seed[i]    = 16'($urandom);
      mdl_mem[i] = seed[i];
    end
    seed[2]    = 16'h1234;
    mdl_mem[2] = 16'h1234;
    wait_clks(5);
    load_bank = 1'b0;
    rst       = 1'b0;
    wait_clks(4);

    check("reset_oe", {31'd0, bus.mdio_oe}, 32'd0);
    check("reset_o", {31'd0, bus.mdio_o}, 32'd1);
    check("reset_wr", {31'd0, bus.reg_wr}, 32'd0);
    check("reset_rd", {31'd0, bus.reg_rd}, 32'd0);
    check("reset_err", {31'd0, frame_err}, 32'd0);
    check("reset_addr", {27'd0, bus.reg_addr}, 32'd0);
    check("reset_wdata", {16'd0, bus.reg_wdata}, 32'd0);

    // Write PHY1 REG5 0xA5C3, then read PHY1 REG2 returning 0x1234.
    send_frame(32, 2'b01, 2'b01, 5'd1, 5'd5, 16'hA5C3, 32, -1, got);
    check("w5_count", n_wr, 32'd1);
    check("w5_addr", {27'd0, wr_addr}, 32'd5);
    check("w5_data", {16'd0, wr_data}, 32'hA5C3);
    send_frame(32, 2'b01, 2'b10, 5'd1, 5'd2, 16'h0000, 32, -1, got);
    check("r2_data", {16'd0, got}, 32'h1234);
    check("r2_count", n_rd, 32'd1);

    // Foreign PHY, then a normal frame must still decode.
    send_frame(32, 2'b01, 2'b10, 5'd3, 5'd7, 16'h0000, 32, -1, got);
    check("foreign_rd", n_rd, 32'd1);
    send_frame(32, 2'b01, 2'b01, 5'd1, 5'd9, 16'h5A0F, 32, -1, got);

    // Short preamble, bad SOF.
    send_frame(31, 2'b01, 2'b01, 5'd1, 5'd12, 16'hBEEF, 32, -1, got);
    check("short_pre_wr", n_wr, 32'd2);
    send_frame(32, 2'b00, 2'b01, 5'd1, 5'd0, 16'h0000, 2, -1, got);
    check("sof_err", n_err, 32'd1);

    // Reset during read DATA bit 7, then a full write.
    send_frame(32, 2'b01, 2'b10, 5'd1, 5'd5, 16'h0000, 32, 22, got);
    send_frame(32, 2'b01, 2'b01, 5'd1, 5'd17, 16'hC0DE, 32, -1, got);
    send_frame(32, 2'b01, 2'b10, 5'd1, 5'd17, 16'h0000, 32, -1, got);
    check("after_rst_rd", {16'd0, got}, 32'hC0DE);

    for (int n = 0; n < 30; n++) begin
      kind = $urandom_range(0, 9);
      pa   = ($urandom_range(0, 3) == 0) ? 5'($urandom) : phy_addr;
      if (kind == 0) begin
        send_frame($urandom_range(32, 40), 2'b00, 2'b00, pa, 5'd0, 16'd0, 2, -1, got);
      end else if (kind == 1) begin
        op = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'b11;
        send_frame($urandom_range(32, 40), 2'b01, op, pa, 5'd0, 16'd0, 4, -1, got);
      end else begin
        op = ($urandom_range(0, 1) == 0) ? 2'b10 : 2'b01;
        send_frame($urandom_range(32, 40), 2'b01, op, pa, 5'($urandom), 16'($urandom),
                   32, -1, got);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
